// File: rtl/mem_access_if.sv
// Data-bus bundle between the MEM stage and the data memory/bus slave.
// The master side issues requests; the slave side answers with ack and read data.
interface mem_access_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: turns EX/MEM load/store ops into one data-bus transaction
// at a time, stalls the pipe while it is outstanding and hands results to MEM/WB.
module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  debug_pc_i,
  output logic [31:0]  debug_pc_o,
  input  logic [4:0]   ex_waddr,
  input  logic         ex_we,
  input  logic [31:0]  ex_wdata,
  input  logic [3:0]   mem_op,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  store_data,
  input  logic [5:0]   stall,
  mem_access_if.master dbus,
  output logic [4:0]   mem_waddr,
  output logic         mem_we,
  output logic [31:0]  mem_wdata,
  output logic         stallreq,
  output logic         addr_err
);
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state, next_state;
  logic [31:0] rdata_q;
  logic        is_load, is_store, misaligned;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_value;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic        unused_stall;

  // Only the MEM/WB hold bit matters here; the other stall bits belong to other stages.
  assign unused_stall = ^{stall[5], stall[3:0]};

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    case (mem_op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load    = 1'b1;
        misaligned = mem_addr[0];
      end
      OP_LW: begin
        is_load    = 1'b1;
        misaligned = |mem_addr[1:0];
      end
      OP_SB: is_store = 1'b1;
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = mem_addr[0];
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = |mem_addr[1:0];
      end
      default: ;
    endcase
  end

  // Little-endian lane selection out of the captured bus word.
  assign byte_val = rdata_q[{mem_addr[1:0], 3'b000} +: 8];
  assign half_val = rdata_q[{mem_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_value = rdata_q;
    case (mem_op)
      OP_LB:   load_value = {{24{byte_val[7]}}, byte_val};
      OP_LBU:  load_value = {24'd0, byte_val};
      OP_LH:   load_value = {{16{half_val[15]}}, half_val};
      OP_LHU:  load_value = {16'd0, half_val};
      default: load_value = rdata_q;
    endcase
  end

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = store_data;
    case (mem_op)
      OP_SB: begin
        store_be    = 4'b0001 << mem_addr[1:0];
        store_wdata = {4{store_data[7:0]}};
      end
      OP_SH: begin
        store_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      if (state == BUS && dbus.dbus_ack)
        rdata_q <= dbus.dbus_rdata;
    end
  end

  always_comb begin
    next_state      = state;
    mem_waddr       = ex_waddr;
    mem_we          = ex_we;
    mem_wdata       = ex_wdata;
    debug_pc_o      = debug_pc_i;
    stallreq        = 1'b0;
    addr_err        = 1'b0;
    dbus.dbus_req   = 1'b0;
    dbus.dbus_we    = 1'b0;
    dbus.dbus_be    = 4'b0000;
    dbus.dbus_addr  = '0;
    dbus.dbus_wdata = '0;
    case (state)
      IDLE: begin
        if (is_load || is_store) begin
          if (misaligned) begin
            addr_err = 1'b1;
            mem_we   = 1'b0;
          end else begin
            stallreq   = 1'b1;
            next_state = BUS;
          end
        end
      end
      BUS: begin
        stallreq        = 1'b1;
        dbus.dbus_req   = 1'b1;
        dbus.dbus_we    = is_store;
        dbus.dbus_be    = is_store ? store_be : 4'b1111;
        dbus.dbus_addr  = {mem_addr[31:2], 2'b00};
        dbus.dbus_wdata = is_store ? store_wdata : 32'd0;
        if (dbus.dbus_ack)
          next_state = DONE;
      end
      DONE: begin
        if (is_load)
          mem_wdata = load_value;
        if (!stall[4])
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset silences the pipeline-facing outputs immediately, before the state register reacts.
    if (rst) begin
      mem_waddr  = 5'd0;
      mem_we     = 1'b0;
      mem_wdata  = 32'd0;
      debug_pc_o = 32'd0;
      stallreq   = 1'b0;
      addr_err   = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed literal cases, then random load/store traffic
// compared every cycle against a transaction-level model of the MEM stage.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] debug_pc_i, debug_pc_o;
  logic [4:0]  ex_waddr, mem_waddr;
  logic        ex_we, mem_we;
  logic [31:0] ex_wdata, mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, store_data;
  logic [5:0]  stall;
  logic        stallreq, addr_err;

  mem_access_if dbus_if ();

  mem_access dut (
    .clk        (clk),
    .rst        (rst),
    .debug_pc_i (debug_pc_i),
    .debug_pc_o (debug_pc_o),
    .ex_waddr   (ex_waddr),
    .ex_we      (ex_we),
    .ex_wdata   (ex_wdata),
    .mem_op     (mem_op),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .stall      (stall),
    .dbus       (dbus_if.master),
    .mem_waddr  (mem_waddr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .stallreq   (stallreq),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [16];

  logic        exp_on = 1'b0;
  logic        exp_chk_mem, exp_chk_dwd;
  logic [4:0]  exp_waddr;
  logic        exp_we, exp_stallreq, exp_addr_err, exp_req, exp_dwe;
  logic [31:0] exp_wdata, exp_pc, exp_daddr, exp_dwdata;
  logic [3:0]  exp_be;

  logic [3:0]  obs_be;
  logic        obs_dwe;
  logic [31:0] obs_daddr, obs_dwdata;
  int          obs_req_cnt;
  logic [31:0] obs_done [8];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  // A store touches size bytes starting at the byte offset; a load reads the whole word.
  function automatic logic [3:0] be_model(input logic [3:0] op, input logic [31:0] addr);
    int sz;
    sz = op_size(op);
    if (!op_store(op)) return 4'hF;
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] data_model(input logic [3:0] op, input logic [31:0] sd);
    logic [31:0] r;
    int sz;
    sz = op_size(op);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] load_model(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
    int sz;
    logic [31:0] v, mask;
    sz = op_size(op);
    if (sz == 4) return word;
    v    = word >> (8 * (addr % 4));
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v    = v & mask;
    if ((op == 4'd1 || op == 4'd3) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) begin
    if (exp_on) begin
      check_output("debug_pc_o", debug_pc_o, exp_pc);
      check_output("stallreq", 32'(stallreq), 32'(exp_stallreq));
      check_output("addr_err", 32'(addr_err), 32'(exp_addr_err));
      check_output("dbus_req", 32'(dbus_if.dbus_req), 32'(exp_req));
      check_output("dbus_we", 32'(dbus_if.dbus_we), 32'(exp_dwe));
      check_output("dbus_be", 32'(dbus_if.dbus_be), 32'(exp_be));
      check_output("dbus_addr", dbus_if.dbus_addr, exp_daddr);
      if (exp_chk_dwd) check_output("dbus_wdata", dbus_if.dbus_wdata, exp_dwdata);
      if (exp_chk_mem) begin
        check_output("mem_waddr", 32'(mem_waddr), 32'(exp_waddr));
        check_output("mem_we", 32'(mem_we), 32'(exp_we));
        check_output("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  // One complete access: issue cycle, nwait bus cycles (ack on the last), then hold+1 DONE cycles.
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                                input int nwait, input int hold);
    int          sz, idx;
    logic        mis;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wd, word, lval, sdata;
    logic [3:0]  be;
    sz  = op_size(op);
    mis = (sz != 0) && ((addr % sz) != 0);
    idx = int'(addr[5:2]);
    wa  = 5'($urandom);
    we  = 1'($urandom);
    wd  = $urandom;
    mem_op = op; mem_addr = addr; store_data = sd;
    ex_waddr = wa; ex_we = we; ex_wdata = wd;
    debug_pc_i = $urandom; stall = 6'($urandom);
    dbus_if.dbus_ack = 1'($urandom); dbus_if.dbus_rdata = $urandom;
    exp_pc = debug_pc_i;
    exp_chk_mem = (sz == 0) || mis; exp_waddr = wa; exp_we = mis ? 1'b0 : we; exp_wdata = wd;
    exp_stallreq = (sz != 0) && !mis; exp_addr_err = mis;
    exp_req = 1'b0; exp_dwe = 1'b0; exp_be = 4'h0; exp_daddr = '0; exp_dwdata = '0; exp_chk_dwd = 1'b1;
    exp_on = 1'b1;
    @(posedge clk); #1;
    if (sz == 0 || mis) return;
    word  = model_mem[idx];
    be    = be_model(op, addr);
    sdata = data_model(op, sd);
    obs_req_cnt = 0;
    for (int i = 1; i <= nwait; i++) begin
      stall = 6'($urandom);
      dbus_if.dbus_ack   = (i == nwait);
      dbus_if.dbus_rdata = (i == nwait) ? word : $urandom;
      exp_chk_mem = 1'b0; exp_stallreq = 1'b1; exp_addr_err = 1'b0; exp_req = 1'b1;
      exp_dwe = op_store(op); exp_be = be; exp_daddr = {addr[31:2], 2'b00};
      exp_dwdata = sdata; exp_chk_dwd = op_store(op);
      @(negedge clk);
      obs_be = dbus_if.dbus_be; obs_dwe = dbus_if.dbus_we;
      obs_daddr = dbus_if.dbus_addr; obs_dwdata = dbus_if.dbus_wdata;
      if (dbus_if.dbus_req) obs_req_cnt++;
      @(posedge clk); #1;
    end
    if (op_store(op))
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[idx][8*b +: 8] = sdata[8*b +: 8];
    lval = op_store(op) ? wd : load_model(op, addr, word);
    for (int j = 0; j <= hold; j++) begin
      stall = 6'($urandom);
      stall[4] = (j < hold);
      dbus_if.dbus_ack = 1'($urandom); dbus_if.dbus_rdata = $urandom;
      exp_chk_mem = 1'b1; exp_waddr = wa; exp_we = we; exp_wdata = lval;
      exp_stallreq = 1'b0; exp_addr_err = 1'b0; exp_req = 1'b0; exp_dwe = 1'b0;
      exp_be = 4'h0; exp_daddr = '0; exp_dwdata = '0; exp_chk_dwd = 1'b1;
      @(negedge clk);
      obs_done[j] = mem_wdata;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    int          sz;
    for (int i = 0; i < 16; i++) model_mem[i] = $urandom;
    rst = 1'b1; mem_op = 4'd5; mem_addr = 32'h3000; store_data = 32'h0;
    ex_waddr = 5'd9; ex_we = 1'b1; ex_wdata = 32'hAAAA5555; debug_pc_i = 32'h400; stall = 6'd0;
    dbus_if.dbus_ack = 1'b0; dbus_if.dbus_rdata = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("rst mem_waddr", 32'(mem_waddr), 32'd0);
    check_output("rst mem_we", 32'(mem_we), 32'd0);
    check_output("rst mem_wdata", mem_wdata, 32'd0);
    check_output("rst debug_pc_o", debug_pc_o, 32'd0);
    check_output("rst stallreq", 32'(stallreq), 32'd0);
    check_output("rst addr_err", 32'(addr_err), 32'd0);
    check_output("rst dbus_req", 32'(dbus_if.dbus_req), 32'd0);

    @(posedge clk); #1;
    rst = 1'b0; mem_op = 4'd0; ex_waddr = 5'd5; ex_we = 1'b1; ex_wdata = 32'h1234; debug_pc_i = 32'h100;
    @(negedge clk);
    check_output("pass mem_waddr", 32'(mem_waddr), 32'd5);
    check_output("pass mem_we", 32'(mem_we), 32'd1);
    check_output("pass mem_wdata", mem_wdata, 32'h1234);
    check_output("pass stallreq", 32'(stallreq), 32'd0);
    check_output("pass debug_pc_o", debug_pc_o, 32'h100);

    @(posedge clk); #1;
    mem_op = 4'd5; mem_addr = 32'h3001;
    @(negedge clk);
    check_output("misal addr_err", 32'(addr_err), 32'd1);
    check_output("misal mem_we", 32'(mem_we), 32'd0);
    check_output("misal dbus_req", 32'(dbus_if.dbus_req), 32'd0);
    check_output("misal stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("misal stays idle", 32'(addr_err), 32'd1);
    @(posedge clk); #1;

    model_mem[0] = 32'h80AB_CDEF;
    apply_stimulus(4'd1, 32'h1003, 32'h0, 3, 0);
    check_output("lb dbus_be", 32'(obs_be), 32'hF);
    check_output("lb dbus_addr", obs_daddr, 32'h1000);
    check_output("lb dbus_we", 32'(obs_dwe), 32'd0);
    check_output("lb req cycles", 32'(obs_req_cnt), 32'd3);
    check_output("lb result", obs_done[0], 32'hFFFF_FF80);
    apply_stimulus(4'd2, 32'h1003, 32'h0, 3, 0);
    check_output("lbu result", obs_done[0], 32'h0000_0080);
    apply_stimulus(4'd7, 32'h2002, 32'h0000_BEEF, 3, 0);
    check_output("sh dbus_we", 32'(obs_dwe), 32'd1);
    check_output("sh dbus_be", 32'(obs_be), 32'hC);
    check_output("sh dbus_wdata", obs_dwdata, 32'hBEEF_BEEF);
    check_output("sh req held", 32'(obs_req_cnt), 32'd3);

    model_mem[2] = 32'hDEAD_BEEF;
    apply_stimulus(4'd5, 32'h1008, 32'h0, 1, 3);
    for (int j = 0; j < 4; j++) check_output("done hold wdata", obs_done[j], 32'hDEAD_BEEF);

    exp_on = 1'b0;
    mem_op = 4'd5; mem_addr = 32'h1008; stall = 6'd0; dbus_if.dbus_ack = 1'b0;
    @(negedge clk);
    check_output("idle after release", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("bus before reset", 32'(dbus_if.dbus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("rst in bus stallreq", 32'(stallreq), 32'd0);
    check_output("rst in bus mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    dbus_if.dbus_ack = 1'b1; dbus_if.dbus_rdata = $urandom;
    @(negedge clk);
    check_output("late ack dbus_req", 32'(dbus_if.dbus_req), 32'd0);
    check_output("late ack dbus_be", 32'(dbus_if.dbus_be), 32'd0);
    check_output("late ack dbus_addr", dbus_if.dbus_addr, 32'd0);
    check_output("late ack stallreq", 32'(stallreq), 32'd0);
    check_output("late ack mem_wdata", mem_wdata, 32'd0);
    check_output("late ack mem_waddr", 32'(mem_waddr), 32'd0);
    check_output("late ack debug_pc_o", debug_pc_o, 32'd0);
    check_output("late ack addr_err", 32'(addr_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dbus_if.dbus_ack = 1'b0;

    for (int t = 0; t < 120; t++) begin
      op   = 4'($urandom_range(0, 15));
      sz   = op_size(op);
      addr = $urandom;
      if (sz != 0 && $urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
      apply_stimulus(op, addr, $urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
    end

    exp_on = 1'b0;
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high (RstEnable = 1), sampled on the rising clk edge.
REQ-003 The block SHALL have port debug_pc_i, input, 32 bits: PC of the instruction in this stage; debug_pc_o, output, 32 bits: the same PC forwarded.
REQ-004 The block SHALL have ports ex_waddr (input, 5 bits), ex_we (input, 1 bit) and ex_wdata (input, 32 bits): destination register, write-enable and ALU result from EX/MEM.
REQ-005 The block SHALL have ports mem_op (input, 4 bits), mem_addr (input, 32 bits) and store_data (input, 32 bits); mem_op encodes 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, and 9-15 behave as none.
REQ-006 The block SHALL have port stall, input, 6 bits: pipeline stall vector; bit 4 means the MEM/WB register is held.
REQ-007 The block SHALL have outputs dbus_req (1 bit), dbus_we (1 bit), dbus_be (4 bits), dbus_addr (32 bits) and dbus_wdata (32 bits): the data-bus request.
REQ-008 The block SHALL have inputs dbus_ack (1 bit) and dbus_rdata (32 bits): data-bus completion and read data.
REQ-009 The block SHALL have outputs mem_waddr (5 bits), mem_we (1 bit) and mem_wdata (32 bits): results to MEM/WB.
REQ-010 The block SHALL have outputs stallreq (1 bit): stall request to the pipeline controller; and addr_err (1 bit): misaligned access flag.

Function
REQ-011 The FSM SHALL have states IDLE, BUS and DONE; a result register rdata_q (32 bits) holds the loaded value.
REQ-012 In IDLE with a none opcode, outputs SHALL be combinational pass-through: mem_waddr=ex_waddr, mem_we=ex_we, mem_wdata=ex_wdata, debug_pc_o=debug_pc_i, stallreq=0, dbus_req=0.
REQ-013 Misaligned access SHALL be detected as LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-014 On a misaligned access in IDLE: addr_err=1, mem_we=0, stallreq=0, no bus request, and the state SHALL remain IDLE.
REQ-015 An aligned memory op in IDLE SHALL drive stallreq=1 combinationally and move to BUS at the next edge.
REQ-016 In BUS: dbus_req=1 and stallreq=1, with dbus_addr={mem_addr[31:2],2'b00}.
REQ-017 In BUS, dbus_we SHALL be 1 for stores and 0 for loads.
REQ-018 Loads in BUS SHALL drive dbus_be=4'b1111.
REQ-019 Stores in BUS SHALL drive byte enables as follows: SB be=1<<addr[1:0]; SH be = addr[1] ? 4'b1100 : 4'b0011; SW be=4'b1111.
REQ-020 Store data SHALL be replicated: SB {4{store_data[7:0]}}, SH {2{store_data[15:0]}}, SW store_data.
REQ-021 In BUS the request SHALL be held stable until dbus_ack=1; on the ack edge the block SHALL capture dbus_rdata into rdata_q and go to DONE, with no timeout.
REQ-022 Load extraction SHALL be little-endian: byte = rdata_q[8*addr[1:0]+:8], half = rdata_q[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW takes the full word.
REQ-023 In DONE: stallreq=0 and dbus_req=0; loads drive mem_wdata=extracted value and mem_we=ex_we; stores pass ex_* through.
REQ-024 DONE SHALL go to IDLE at the next edge with stall[4]=0, and SHALL stay in DONE while stall[4]=1.
REQ-025 In BUS, stallreq=1 SHALL apply regardless of stall; EX/MEM inputs are held stable by upstream while stallreq=1.
REQ-026 dbus_ack SHALL be ignored in IDLE and DONE.
REQ-027 addr_err SHALL be 0 in BUS and DONE.
REQ-028 dbus_* outputs SHALL be 0 when dbus_req=0.
REQ-029 Total access latency SHALL be 1 request-setup cycle + N wait cycles + 1 DONE cycle, where N≥1 is the cycle count up to and including the ack.

Reset
REQ-030 While rst=1 at a clock edge, the FSM SHALL go to IDLE and rdata_q SHALL clear to 0; reset in BUS SHALL drop dbus_req at the following cycle without waiting for ack.
REQ-031 While rst=1, the outputs mem_waddr=0 (NOPRegAddr), mem_we=0, mem_wdata=0, debug_pc_o=0, stallreq=0, addr_err=0 SHALL be forced combinationally.

Verification
REQ-032 Pass-through: mem_op=0, ex_waddr=5, ex_we=1, ex_wdata=0x1234 -> same cycle mem_waddr=5, mem_we=1, mem_wdata=0x1234, stallreq=0.
REQ-033 LB: addr=0x1003, ack after 2 wait cycles with rdata=0x80AB_CDEF -> dbus_be=1111, dbus_addr=0x1000, DONE mem_wdata=0xFFFF_FF80; LBU gives 0x0000_0080.
REQ-034 SH: addr=0x2002, store_data=0x0000_BEEF -> dbus_we=1, be=1100, wdata=0xBEEF_BEEF, dbus_req held until ack.
REQ-035 Misaligned LW: addr=0x3001 -> addr_err=1, mem_we=0, dbus_req=0, stallreq=0.
REQ-036 DONE hold with stall[4]=1 for 3 cycles -> mem_wdata stable for 3 cycles and IDLE on release.
REQ-037 rst=1 in BUS before ack -> dbus_req=0 after the edge; a late ack then leaves all outputs at their reset values.
